// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, R-type
// funct codes and the aluop values driven by the main control unit.
package alu_pkg;

   // Decoded ALU operation (gout)
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // R-type funct field values
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;

   // aluop encodings from the main decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps the main-control aluop and the instruction
// funct field to the 3-bit ALU operation code.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] gout
);

   // aluop selects a fixed ADD/SUB; any aluop with bit 1 set decodes funct
   always_comb begin
      gout = ALU_ADD;
      casez (aluop)
         ALUOP_ADD: gout = ALU_ADD;
         ALUOP_SUB: gout = ALU_SUB;
         2'b1?: begin
            case (funct)
               FUNCT_ADD: gout = ALU_ADD;
               FUNCT_SUB: gout = ALU_SUB;
               FUNCT_AND: gout = ALU_AND;
               FUNCT_OR:  gout = ALU_OR;
               FUNCT_SLT: gout = ALU_SLT;
               FUNCT_NOR: gout = ALU_NOR;
               default:   gout = ALU_ADD;
            endcase
         end
         default: gout = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage of the single-cycle MIPS datapath: ALU control, 32-bit ALU
// with N/Z/V flags, the PC+4 and branch-target adders, and a registered
// status register sampled when flag_en is high.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm_sext,
   input  logic             flag_en,
   output logic [2:0]       gout,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target,
   output logic             z_q,
   output logic             n_q,
   output logic             v_q
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt_bit;

   alu_ctrl_dec u_ctrl (
      .aluop (aluop),
      .funct (funct),
      .gout  (gout)
   );

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   assign add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
   assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);

   // When the signs differ the negative operand is the smaller one; only
   // same-sign operands use the difference, where a - b cannot overflow.
   assign slt_bit = (op_a[MSB] != op_b[MSB]) ? op_a[MSB] : diff[MSB];

   // ALU operation select and overflow qualification
   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (gout)
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_NOR: result = ~(op_a | op_b);
         ALU_ADD: begin
            result = sum;
            ovf    = add_ovf;
         end
         ALU_SUB: begin
            result = diff;
            ovf    = sub_ovf;
         end
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);
   assign neg  = result[MSB];

   // Shifting the full immediate drops its top two bits, matching
   // {imm_sext[WIDTH-3:0], 2'b00}; both adders wrap with no carry out.
   assign pc_plus4      = pc + WIDTH'(4);
   assign branch_target = pc_plus4 + (imm_sext << 2);

   // Status register: async clear, load on flag_en, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q <= 1'b0;
         n_q <= 1'b0;
         v_q <= 1'b0;
      end else if (flag_en) begin
         z_q <= zero;
         n_q <= neg;
         v_q <= ovf;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: table of ALU vectors with hand-computed
// results and flags, a PC-adder table, and sequences for reset and flag hold.
module tb_alu_exec_stage;

   logic        clk;
   logic        rst_n;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] pc;
   logic [31:0] imm_sext;
   logic        flag_en;
   logic [2:0]  gout;
   logic [31:0] result;
   logic        zero;
   logic        neg;
   logic        ovf;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic        z_q;
   logic        n_q;
   logic        v_q;

   int n_chk;
   int n_err;

   alu_exec_stage #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .aluop         (aluop),
      .funct         (funct),
      .op_a          (op_a),
      .op_b          (op_b),
      .pc            (pc),
      .imm_sext      (imm_sext),
      .flag_en       (flag_en),
      .gout          (gout),
      .result        (result),
      .zero          (zero),
      .neg           (neg),
      .ovf           (ovf),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .z_q           (z_q),
      .n_q           (n_q),
      .v_q           (v_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  gout;
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        v;
   } alu_vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] p4;
      logic [31:0] bt;
   } pc_vec_t;

   alu_vec_t av[14];
   pc_vec_t  pv[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;

      //        aluop  funct      a             b             gout    result        z     n     v
      av[0]  = '{2'b10, 6'b100010, 32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b0};
      av[1]  = '{2'b00, 6'b000000, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b1};
      av[2]  = '{2'b01, 6'b000000, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
      av[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
      av[4]  = '{2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0};
      av[5]  = '{2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
      av[6]  = '{2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0};
      av[7]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b1, 1'b0};
      av[8]  = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0};
      av[9]  = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 32'h000F000F, 1'b0, 1'b0, 1'b0};
      av[10] = '{2'b10, 6'b000000, 32'h00000003, 32'h00000004, 3'b010, 32'h00000007, 1'b0, 1'b0, 1'b0};
      av[11] = '{2'b10, 6'b100000, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b0};
      av[12] = '{2'b11, 6'b100010, 32'h0000000A, 32'h00000003, 3'b110, 32'h00000007, 1'b0, 1'b0, 1'b0};
      av[13] = '{2'b10, 6'b100010, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b0, 1'b1, 1'b1};

      pv[0] = '{32'h0000001C, 32'hFFFFFFFE, 32'h00000020, 32'h00000018};
      pv[1] = '{32'h00000000, 32'h00000001, 32'h00000004, 32'h00000008};
      pv[2] = '{32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000};
      pv[3] = '{32'h00000100, 32'h00000010, 32'h00000104, 32'h00000144};

      // Reset asserted with flag_en high and a zero result
      rst_n    = 1'b0;
      flag_en  = 1'b1;
      aluop    = 2'b00;
      funct    = 6'b000000;
      op_a     = 32'h0;
      op_b     = 32'h0;
      pc       = 32'h0;
      imm_sext = 32'h0;
      #1;
      check("reset_z_q", 32'(z_q), 32'd0);
      check("reset_n_q", 32'(n_q), 32'd0);
      check("reset_v_q", 32'(v_q), 32'd0);
      check("reset_comb_zero", 32'(zero), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("reset_wins_z_q", 32'(z_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("release_z_q", 32'(z_q), 32'd1);
      $display("reset release: z_q=%0b n_q=%0b v_q=%0b", z_q, n_q, v_q);

      // ALU table: combinational checks, then registered flags after the edge
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         aluop   = av[i].aluop;
         funct   = av[i].funct;
         op_a    = av[i].a;
         op_b    = av[i].b;
         flag_en = 1'b1;
         #1;
         check($sformatf("v%0d_gout", i), 32'(gout), 32'(av[i].gout));
         check($sformatf("v%0d_result", i), result, av[i].res);
         check($sformatf("v%0d_zero", i), 32'(zero), 32'(av[i].z));
         check($sformatf("v%0d_neg", i), 32'(neg), 32'(av[i].n));
         check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(av[i].v));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_flags_q", i), {29'd0, n_q, z_q, v_q},
               {29'd0, av[i].n, av[i].z, av[i].v});
         $display("vec %0d: aluop=%b funct=%b a=%h b=%h gout=%b result=%h zero=%b neg=%b ovf=%b",
                  i, aluop, funct, op_a, op_b, gout, result, zero, neg, ovf);
      end

      // PC adder table
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pc       = pv[i].pc;
         imm_sext = pv[i].imm;
         #1;
         check($sformatf("pc%0d_plus4", i), pc_plus4, pv[i].p4);
         check($sformatf("pc%0d_target", i), branch_target, pv[i].bt);
         $display("pc %0d: pc=%h imm=%h pc_plus4=%h branch_target=%h",
                  i, pc, imm_sext, pc_plus4, branch_target);
      end

      // Load N=1,V=1,Z=0 then hold for three edges with differing operands
      @(negedge clk);
      aluop   = 2'b00;
      op_a    = 32'h7FFFFFFF;
      op_b    = 32'h00000001;
      flag_en = 1'b1;
      @(posedge clk);
      #1;
      check("hold_load", {29'd0, n_q, z_q, v_q}, 32'b101);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         flag_en = 1'b0;
         op_a    = 32'(k);
         op_b    = 32'd0 - 32'(k);
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_flags", k), {29'd0, n_q, z_q, v_q}, 32'b101);
         $display("hold %0d: zero=%b z_q=%b n_q=%b v_q=%b", k, zero, z_q, n_q, v_q);
      end

      // Asynchronous clear away from any clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", {29'd0, n_q, z_q, v_q}, 32'b000);
      $display("async reset: z_q=%0b n_q=%0b v_q=%0b", z_q, n_q, v_q);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
